// File: rtl/chime_pkg.sv
// Shared types and helpers for the polyphonic chime: mixer width, note bundle
// and the sign convention that maps the phase MSB onto the square-wave sample.
package chime_pkg;

  localparam int NOTE_INC_W = 24;
  localparam int NOTE_AMP_W = 8;

  // Phase MSB value that produces the positive half of the square wave.
  localparam logic SAMPLE_POS_MSB = 1'b0;

  typedef struct packed {
    logic [NOTE_INC_W-1:0] inc;
    logic [NOTE_AMP_W-1:0] amp;
  } note_t;

  // Worst-case signed sum of voices*(2^amp_w - 1) fits in this width.
  function automatic int mix_w(input int amp_w, input int voices);
    return amp_w + 1 + $clog2(voices);
  endfunction

endpackage

// File: rtl/chime_voice.sv
// One square-wave voice: phase accumulator gated by a decaying amplitude
// envelope. A load always takes priority over a coincident decay tick.
module chime_voice
  import chime_pkg::*;
#(
  parameter int PHASE_W     = 24,
  parameter int AMP_W       = 8,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    tick,
  input  logic [PHASE_W-1:0]      load_inc,
  input  logic [AMP_W-1:0]        load_amp,
  output logic signed [AMP_W:0]   sample,
  output logic                    active
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] inc;
  logic [AMP_W-1:0]   amp;
  logic [AMP_W-1:0]   amp_shr;
  logic [AMP_W-1:0]   decay_step;

  // Step is never below 1 so every envelope reaches zero in finite ticks.
  assign amp_shr    = amp >> DECAY_SHIFT;
  assign decay_step = (amp_shr == '0) ? AMP_W'(1) : amp_shr;
  assign active     = (amp != '0);

  assign sample = (phase[PHASE_W-1] == SAMPLE_POS_MSB) ? $signed({1'b0, amp})
                                                       : -$signed({1'b0, amp});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      inc   <= '0;
      amp   <= '0;
    end else if (load) begin
      phase <= '0;
      inc   <= load_inc;
      amp   <= load_amp;
    end else if (amp != '0) begin
      phase <= phase + inc;
      if (tick) begin
        amp <= amp - decay_step;
      end
    end
  end

endmodule

// File: rtl/poly_chime_dsm.sv
// Polyphonic chime: note allocator with round-robin stealing, VOICES decaying
// square voices, registered mixer and a first-order 1-bit delta-sigma DAC.
module poly_chime_dsm
  import chime_pkg::*;
#(
  parameter int VOICES      = 4,
  parameter int PHASE_W     = 24,
  parameter int AMP_W       = 8,
  parameter int TICK_DIV    = 48000,
  parameter int DECAY_SHIFT = 3
) (
  input  logic               CK_i,
  input  logic               ARST_i,
  input  logic               NOTE_VALID_i,
  output logic               NOTE_READY_o,
  input  logic [PHASE_W-1:0] NOTE_INC_i,
  input  logic [AMP_W-1:0]   NOTE_AMP_i,
  output logic               TIMING_1MS_o,
  output logic [VOICES-1:0]  ACTIVE_o,
  output logic               AUDIO_L_o,
  output logic               AUDIO_R_o
);

  localparam int MIX_W = mix_w(AMP_W, VOICES);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PTR_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  logic [CNT_W-1:0]        tick_cnt;
  logic                    tick_q;
  logic                    ready_q;
  logic                    accept;
  logic                    note_live;
  logic                    free_found;
  logic [PTR_W-1:0]        target;
  logic [PTR_W-1:0]        steal_ptr;
  logic [VOICES-1:0]       load_vec;
  logic [VOICES-1:0]       active;
  logic signed [AMP_W:0]   samples [VOICES];
  logic signed [MIX_W-1:0] mix_sum;
  logic signed [MIX_W-1:0] mix_q;
  logic [MIX_W-1:0]        dsm_u;
  logic [MIX_W:0]          dsm_sum;
  logic [MIX_W-1:0]        dsm_acc;
  logic                    audio_q;

  assign accept       = NOTE_VALID_i && ready_q;
  assign note_live    = accept && (NOTE_AMP_i != '0);
  assign NOTE_READY_o = ready_q;
  assign TIMING_1MS_o = tick_q;
  assign ACTIVE_o     = active;
  assign AUDIO_L_o    = audio_q;
  assign AUDIO_R_o    = audio_q;

  // The pulse is registered so it lands exactly TICK_DIV cycles after release.
  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      ready_q  <= 1'b1;
      tick_q   <= (tick_cnt == CNT_W'(TICK_DIV - 1));
      tick_cnt <= (tick_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
    end
  end

  always_comb begin
    free_found = 1'b0;
    target     = '0;
    load_vec   = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (!free_found && !active[i]) begin
        free_found = 1'b1;
        target     = PTR_W'(i);
      end
    end
    if (!free_found) begin
      target = steal_ptr;
    end
    if (note_live) begin
      load_vec[target] = 1'b1;
    end
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      steal_ptr <= '0;
    end else if (note_live && !free_found) begin
      steal_ptr <= (steal_ptr == PTR_W'(VOICES - 1)) ? '0 : steal_ptr + 1'b1;
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    chime_voice #(
      .PHASE_W     (PHASE_W),
      .AMP_W       (AMP_W),
      .DECAY_SHIFT (DECAY_SHIFT)
    ) u_voice (
      .clk      (CK_i),
      .rst      (ARST_i),
      .load     (load_vec[v]),
      .tick     (tick_q),
      .load_inc (NOTE_INC_i),
      .load_amp (NOTE_AMP_i),
      .sample   (samples[v]),
      .active   (active[v])
    );
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < VOICES; i++) begin
      mix_sum = mix_sum + MIX_W'(samples[i]);
    end
  end

  // Adding the half-scale offset modulo 2^MIX_W is just an MSB flip.
  assign dsm_u   = mix_q ^ {1'b1, {(MIX_W-1){1'b0}}};
  assign dsm_sum = {1'b0, dsm_acc} + {1'b0, dsm_u};

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      mix_q   <= '0;
      dsm_acc <= '0;
      audio_q <= 1'b0;
    end else begin
      mix_q   <= mix_sum;
      dsm_acc <= dsm_sum[MIX_W-1:0];
      audio_q <= dsm_sum[MIX_W];
    end
  end

endmodule

// File: tb/tb_poly_chime_dsm.sv
// Scoreboard bench for poly_chime_dsm: directed notes push hand-computed
// expectations tagged with a cycle number; a monitor compares them per cycle.
module tb_poly_chime_dsm;
  import chime_pkg::*;

  localparam int VOICES      = 4;
  localparam int PHASE_W     = 24;
  localparam int AMP_W       = 8;
  localparam int TICK_DIV    = 100;
  localparam int DECAY_SHIFT = 2;
  localparam int MIX_W       = 11;

  typedef enum int {K_READY, K_ACTIVE, K_AUDIO, K_TIMING, K_MIX, K_MARK, K_ONES} kind_e;

  typedef struct {
    int    cyc;
    kind_e kind;
    int    exp;
    int    tol;
    string name;
  } exp_t;

  exp_t sb[$];

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid = 1'b0;
  logic [PHASE_W-1:0] inc = '0;
  logic [AMP_W-1:0]   amp = '0;
  logic               ready;
  logic               timing;
  logic [VOICES-1:0]  active;
  logic               audio_l;
  logic               audio_r;
  logic signed [MIX_W-1:0] mix_mon;

  int cyc       = 0;
  int checks    = 0;
  int errors    = 0;
  int ones_cnt  = 0;
  int ones_mark = 0;

  poly_chime_dsm #(
    .VOICES      (VOICES),
    .PHASE_W     (PHASE_W),
    .AMP_W       (AMP_W),
    .TICK_DIV    (TICK_DIV),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) dut (
    .CK_i         (clk),
    .ARST_i       (rst),
    .NOTE_VALID_i (valid),
    .NOTE_READY_o (ready),
    .NOTE_INC_i   (inc),
    .NOTE_AMP_i   (amp),
    .TIMING_1MS_o (timing),
    .ACTIVE_o     (active),
    .AUDIO_L_o    (audio_l),
    .AUDIO_R_o    (audio_r)
  );

  assign mix_mon = dut.mix_q;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
    checks++;
    if (actual < expected - tol || actual > expected + tol) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d (tol %0d)", name, cyc, actual, expected, tol);
    end
  endtask

  task automatic expectAt(input int c, input kind_e k, input int e, input string n, input int tol = 0);
    sb.push_back('{c, k, e, tol, n});
  endtask

  // Monitor: one pass per cycle, on the falling edge, away from DUT updates.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        ones_cnt = ones_cnt + int'(audio_l);
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].cyc == cyc) begin
            case (sb[i].kind)
              K_READY:  checkOutput(sb[i].name, int'(ready), sb[i].exp, sb[i].tol);
              K_ACTIVE: checkOutput(sb[i].name, int'(active), sb[i].exp, sb[i].tol);
              K_AUDIO: begin
                checkOutput({sb[i].name, "_L"}, int'(audio_l), sb[i].exp, sb[i].tol);
                checkOutput({sb[i].name, "_R"}, int'(audio_r), sb[i].exp, sb[i].tol);
              end
              K_TIMING: checkOutput(sb[i].name, int'(timing), sb[i].exp, sb[i].tol);
              K_MIX:    checkOutput(sb[i].name, int'(mix_mon), sb[i].exp, sb[i].tol);
              K_MARK:   ones_mark = ones_cnt;
              K_ONES:   checkOutput(sb[i].name, ones_cnt - ones_mark, sb[i].exp, sb[i].tol);
              default:  ;
            endcase
            sb.delete(i);
          end else if (sb[i].cyc < cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: expected at cycle %0d, never compared (now %0d)", sb[i].name, sb[i].cyc, cyc);
            sb.delete(i);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic finishTest(input int last);
    waitCycle(last + 1);
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: left in scoreboard (due cycle %0d)", sb[i].name, sb[i].cyc);
    end
    sb.delete();
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic applyStimulus(input int c, input note_t n);
    while (cyc < c) @(negedge clk);
    valid = 1'b1;
    inc   = n.inc;
    amp   = n.amp;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    int env_tbl [10] = '{12, 9, 7, 6, 5, 4, 3, 2, 1, 0};

    // Reset values, ready, silence pattern and first timing pulse.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", int'(ready), 0, 0);
    checkOutput("rst_active", int'(active), 0, 0);
    checkOutput("rst_audio", int'(audio_l | audio_r), 0, 0);
    checkOutput("rst_timing", int'(timing), 0, 0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    expectAt(0, K_READY, 0, "ready_c0");
    expectAt(0, K_ACTIVE, 0, "active_c0");
    expectAt(0, K_AUDIO, 0, "audio_c0");
    expectAt(0, K_MIX, 0, "mix_c0");
    expectAt(1, K_READY, 1, "ready_c1");
    for (int k = 1; k <= 6; k++) expectAt(k, K_AUDIO, (k % 2 == 0) ? 1 : 0, "audio_silence");
    expectAt(99, K_TIMING, 0, "timing_c99");
    expectAt(100, K_TIMING, 1, "timing_first");
    expectAt(101, K_TIMING, 0, "timing_c101");
    expectAt(199, K_TIMING, 0, "timing_c199");
    expectAt(200, K_TIMING, 1, "timing_second");
    finishTest(200);

    // Single note: square period of 2 cycles, decay visible after tick.
    doReset(2);
    expectAt(2, K_ACTIVE, 0, "single_active_c2");
    expectAt(3, K_ACTIVE, 1, "single_active_c3");
    expectAt(3, K_MIX, 0, "single_mix_c3");
    expectAt(4, K_MIX, 100, "single_mix_c4");
    expectAt(5, K_MIX, -100, "single_mix_c5");
    expectAt(6, K_MIX, 100, "single_mix_c6");
    expectAt(10, K_MARK, 0, "single_mark");
    expectAt(101, K_MIX, -100, "single_mix_c101");
    expectAt(102, K_MIX, 75, "single_mix_c102");
    expectAt(103, K_MIX, -75, "single_mix_c103");
    expectAt(1034, K_ONES, 512, "single_density", 1);
    applyStimulus(2, '{inc: 24'h800000, amp: 8'd100});
    finishTest(1034);

    // Envelope: constant-phase note, amplitude steps visible directly in mix.
    doReset(2);
    expectAt(4, K_MIX, 16, "env_mix_start");
    expectAt(101, K_MIX, 16, "env_mix_pre_tick");
    for (int n = 1; n <= 10; n++) expectAt(100 * n + 2, K_MIX, env_tbl[n-1], "env_step");
    expectAt(1000, K_ACTIVE, 1, "env_active_c1000");
    expectAt(1001, K_ACTIVE, 0, "env_active_c1001");
    applyStimulus(2, '{inc: 24'h0, amp: 8'd16});
    finishTest(1002);

    // Allocation, stealing and zero-amplitude discard.
    doReset(2);
    expectAt(3, K_ACTIVE, 1, "alloc_active_v0");
    expectAt(4, K_ACTIVE, 3, "alloc_active_v1");
    expectAt(4, K_MIX, 50, "alloc_mix_c4");
    expectAt(5, K_ACTIVE, 7, "alloc_active_v2");
    expectAt(5, K_MIX, 90, "alloc_mix_c5");
    expectAt(6, K_ACTIVE, 15, "alloc_active_v3");
    expectAt(6, K_MIX, 120, "alloc_mix_c6");
    expectAt(7, K_MIX, 140, "alloc_mix_full");
    expectAt(8, K_MIX, 95, "steal_v0");
    expectAt(9, K_MIX, 62, "steal_v1");
    expectAt(10, K_ACTIVE, 15, "zero_amp_active");
    expectAt(10, K_MIX, 62, "zero_amp_mix");
    expectAt(11, K_MIX, 41, "steal_v2");
    applyStimulus(2, '{inc: 24'h0, amp: 8'd50});
    applyStimulus(3, '{inc: 24'h0, amp: 8'd40});
    applyStimulus(4, '{inc: 24'h0, amp: 8'd30});
    applyStimulus(5, '{inc: 24'h0, amp: 8'd20});
    applyStimulus(6, '{inc: 24'h0, amp: 8'd5});
    applyStimulus(7, '{inc: 24'h0, amp: 8'd7});
    applyStimulus(8, '{inc: 24'h0, amp: 8'd0});
    applyStimulus(9, '{inc: 24'h0, amp: 8'd9});
    finishTest(11);

    // Load colliding with a tick on a stolen voice; DC density check.
    doReset(2);
    expectAt(2, K_ACTIVE, 0, "zero_amp_idle");
    expectAt(3, K_MIX, 0, "zero_amp_idle_mix");
    expectAt(6, K_ACTIVE, 15, "coll_active_full");
    expectAt(7, K_MIX, 160, "coll_mix_full");
    expectAt(10, K_MARK, 0, "coll_mark");
    expectAt(90, K_ONES, 46, "coll_density", 1);
    expectAt(101, K_MIX, 160, "coll_mix_c101");
    expectAt(101, K_ACTIVE, 15, "coll_active_c101");
    expectAt(102, K_MIX, 123, "coll_load_wins");
    expectAt(103, K_MIX, 123, "coll_mix_c103");
    applyStimulus(1, '{inc: 24'h0, amp: 8'd0});
    for (int c = 2; c <= 5; c++) applyStimulus(c, '{inc: 24'h0, amp: 8'd40});
    applyStimulus(100, '{inc: 24'h0, amp: 8'd33});
    finishTest(103);

    // Reset pulse with three voices sounding.
    doReset(2);
    expectAt(20, K_ACTIVE, 7, "midrst_active_before");
    for (int c = 2; c <= 4; c++) applyStimulus(c, '{inc: 24'h800000, amp: 8'd60});
    finishTest(20);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_active_async", int'(active), 0, 0);
    checkOutput("midrst_mix_async", int'(mix_mon), 0, 0);
    checkOutput("midrst_ready_async", int'(ready), 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    expectAt(1, K_READY, 1, "midrst_ready");
    for (int k = 1; k <= 6; k++) expectAt(k, K_AUDIO, (k % 2 == 0) ? 1 : 0, "midrst_audio");
    expectAt(3, K_ACTIVE, 0, "midrst_active_after");
    expectAt(3, K_MIX, 0, "midrst_mix_after");
    finishTest(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
